// File: rtl/dcache_wb_param.sv
// Direct-mapped, write-back, write-allocate data cache with multi-word lines and burst RAM port.
// Define DCACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module dcache_wb_param #(
  parameter int unsigned NUM_LINES  = 256,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        rreq,
  input  logic        wreq,
  input  logic [31:0] wdata,
  input  logic [3:0]  byte_enable,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        wvalid,
  output logic        busy,
  output logic [31:0] ram_awaddr,
  output logic [7:0]  ram_awlen,
  output logic        ram_awvalid,
  input  logic        ram_awready,
  output logic [31:0] ram_wdata,
  input  logic        ram_wvalid,
  output logic        ram_wready,
  input  logic        ram_wlast,
  output logic [31:0] ram_araddr,
  output logic [7:0]  ram_arlen,
  output logic        ram_arvalid,
  input  logic        ram_arready,
  input  logic [31:0] ram_rdata,
  input  logic        ram_rvalid,
  output logic        ram_rready,
  input  logic        ram_rlast
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int unsigned WB = $clog2(LINE_WORDS);
  localparam int unsigned IB = $clog2(NUM_LINES);
  localparam int unsigned TB = 30 - WB - IB;
  localparam int unsigned FW = IB + WB;
  localparam int unsigned KW = WB + 1;
  localparam logic [31:0]   LINE_MASK = ~32'(LINE_WORDS * 4 - 1);
  localparam logic [KW-1:0] BEATS     = KW'(LINE_WORDS);
  localparam logic [7:0]    LEN       = 8'(LINE_WORDS);

  typedef enum logic [2:0] {S_IDLE, S_WRITE_BACK, S_WWAIT, S_ALLOCATE, S_RWAIT} state_t;

  state_t                 state_q, state_d;
  logic [31:0]            miss_addr_q, miss_addr_d;
  logic [KW-1:0]          k_q, k_d;
  logic [NUM_LINES-1:0]   valid_q, valid_d, dirty_q, dirty_d;
  logic [31:0]            awaddr_q, awaddr_d, wdata_q, wdata_d, araddr_q, araddr_d;
  logic [7:0]             awlen_q, awlen_d, arlen_q, arlen_d;
  logic                   awvalid_q, awvalid_d, wready_q, wready_d;
  logic                   arvalid_q, arvalid_d, rready_q, rready_d, busy_q, busy_d;

  logic [TB-1:0]          tag_mem  [NUM_LINES];
  logic [31:0]            data_mem [NUM_LINES*LINE_WORDS];

  logic [IB-1:0] req_idx, miss_idx;
  logic [TB-1:0] req_tag, miss_tag;
  logic [FW-1:0] req_flat, wb_first_flat, wb_next_flat, fill_flat;
  logic [31:0]   victim_base;
  logic          hit_c, idle_c, miss_c, fill_we_c, tag_we_c;

  assign req_idx       = IB'(addr >> (2 + WB));
  assign req_tag       = TB'(addr >> (2 + WB + IB));
  assign req_flat      = FW'(addr >> 2);
  assign miss_idx      = IB'(miss_addr_q >> (2 + WB));
  assign miss_tag      = TB'(miss_addr_q >> (2 + WB + IB));
  assign victim_base   = 32'(miss_idx) << WB;
  assign wb_first_flat = FW'(victim_base);
  assign wb_next_flat  = FW'(victim_base + 32'(k_q) + 32'd1);
  assign fill_flat     = FW'(victim_base + 32'(k_q));

  assign hit_c  = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign idle_c = (state_q == S_IDLE);
  assign miss_c = idle_c && (rreq || wreq) && !hit_c;
  assign wvalid = wreq && hit_c && idle_c;
  assign rvalid = rreq && !wreq && hit_c && idle_c;
  assign rdata  = rvalid ? data_mem[req_flat] : 32'd0;

  // Beats beyond the line length are dropped; the line is only valid after the last beat.
  assign fill_we_c = (state_q == S_RWAIT) && ram_rvalid && rready_q && (k_q < BEATS);
  assign tag_we_c  = (state_q == S_RWAIT) && ram_rvalid && rready_q && ram_rlast;

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    k_d         = k_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    awaddr_d    = awaddr_q;
    awlen_d     = awlen_q;
    awvalid_d   = awvalid_q;
    wdata_d     = wdata_q;
    wready_d    = wready_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    case (state_q)
      S_IDLE: begin
        if (wvalid) dirty_d[req_idx] = 1'b1;
        if (miss_c) begin
          miss_addr_d = addr;
          k_d         = '0;
          if (dirty_q[req_idx]) begin
            state_d   = S_WRITE_BACK;
            awaddr_d  = 32'({tag_mem[req_idx], req_idx}) << (2 + WB);
            awlen_d   = LEN;
            awvalid_d = 1'b1;
          end else begin
            state_d   = S_ALLOCATE;
            araddr_d  = addr & LINE_MASK;
            arlen_d   = LEN;
            arvalid_d = 1'b1;
          end
        end
      end
      S_WRITE_BACK: begin
        if (ram_awready) begin
          state_d   = S_WWAIT;
          awvalid_d = 1'b0;
          wready_d  = 1'b1;
          k_d       = '0;
          wdata_d   = data_mem[wb_first_flat];
        end
      end
      S_WWAIT: begin
        if (ram_wvalid && wready_q) begin
          if (ram_wlast) begin
            state_d           = S_ALLOCATE;
            wready_d          = 1'b0;
            dirty_d[miss_idx] = 1'b0;
            k_d               = '0;
            araddr_d          = miss_addr_q & LINE_MASK;
            arlen_d           = LEN;
            arvalid_d         = 1'b1;
          end else if (k_q < BEATS) begin
            k_d     = k_q + KW'(1);
            wdata_d = data_mem[wb_next_flat];
          end
        end
      end
      S_ALLOCATE: begin
        if (ram_arready) begin
          state_d   = S_RWAIT;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          k_d       = '0;
        end
      end
      S_RWAIT: begin
        if (ram_rvalid && rready_q) begin
          if (k_q < BEATS) k_d = k_q + KW'(1);
          if (ram_rlast) begin
            state_d           = S_IDLE;
            rready_d          = 1'b0;
            valid_d[miss_idx] = 1'b1;
            dirty_d[miss_idx] = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      miss_addr_q <= '0;
      k_q         <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
      awaddr_q    <= '0;
      awlen_q     <= '0;
      awvalid_q   <= 1'b0;
      wdata_q     <= '0;
      wready_q    <= 1'b0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      k_q         <= k_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      awaddr_q    <= awaddr_d;
      awlen_q     <= awlen_d;
      awvalid_q   <= awvalid_d;
      wdata_q     <= wdata_d;
      wready_q    <= wready_d;
      araddr_q    <= araddr_d;
      arlen_q     <= arlen_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      busy_q      <= busy_d;
    end
  end

  // Storage arrays carry no reset; validity is governed by valid_q.
  always_ff @(posedge clk) begin
    if (wvalid) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_enable[b]) data_mem[req_flat][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (fill_we_c) data_mem[fill_flat] <= ram_rdata;
    if (tag_we_c) tag_mem[miss_idx] <= miss_tag;
  end

  assign busy        = busy_q;
  assign ram_awaddr  = awaddr_q;
  assign ram_awlen   = awlen_q;
  assign ram_awvalid = awvalid_q;
  assign ram_wdata   = wdata_q;
  assign ram_wready  = wready_q;
  assign ram_araddr  = araddr_q;
  assign ram_arlen   = arlen_q;
  assign ram_arvalid = arvalid_q;
  assign ram_rready  = rready_q;

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if ((rvalid || wvalid) && (hit_count_q != 32'hFFFF_FFFF)) hit_count_d = hit_count_q + 32'd1;
    if (miss_c && (miss_count_q != 32'hFFFF_FFFF)) miss_count_d = miss_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule
